mem_access_unit: RTL and testbench

Load/store controller between the processor's MEM stage and the 64-word data RAM. It accepts one load or store request at a time from the pipeline, range-checks and converts the byte address into a RAM word index, and sequences the RAM's write-enable and address lines. It absorbs the RAM's one-cycle registered read latency and returns a single-cycle acknowledge with read data or an error flag.

---
 rtl/mem_access_unit_pkg.sv | 15 +
 rtl/mem_access_unit.sv | 103 ++++++++++
 tb/tb_mem_access_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the MEM-stage load/store controller: FSM state
// encoding and default RAM depth.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ISSUE   = 3'd1,
    RD_CAPTURE = 3'd2,
    WR_ISSUE   = 3'd3,
    RESP       = 3'd4
  } state_t;

  localparam int DEPTH_DEFAULT = 64;

endpackage

// File: rtl/mem_access_unit.sv
// Load/store controller between the MEM stage and a word-addressed data RAM
// with one-cycle registered read latency; single outstanding request.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int RAM_AW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we_in,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       wdata_in,
  output logic              ready,
  output logic              ack,
  output logic              err,
  output logic [31:0]       rdata_out,
  output logic              ram_wre,
  output logic [RAM_AW-1:0] ram_add,
  output logic [31:0]       ram_data_in,
  input  logic [31:0]       ram_data_out
);

  state_t            state;
  state_t            state_next;
  logic              err_q;
  logic              err_next;
  logic              addr_bad;
  logic [RAM_AW-1:0] word_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  // Only the word index of the byte address is ever needed after the check.
  assign addr_bad = (addr_in[1:0] != 2'b00) || (addr_in[31:2] >= 30'(DEPTH));

  assign ram_add     = word_q;
  assign ram_data_in = wdata_q;
  assign rdata_out   = rdata_q;

  // Next-state and error-flag decode
  always_comb begin
    state_next = state;
    err_next   = err_q;
    case (state)
      IDLE: begin
        if (req) begin
          if (addr_bad) begin
            state_next = RESP;
            err_next   = 1'b1;
          end else if (we_in) begin
            state_next = WR_ISSUE;
          end else begin
            state_next = RD_ISSUE;
          end
        end else begin
          state_next = IDLE;
        end
      end
      RD_ISSUE:   state_next = RD_CAPTURE;
      RD_CAPTURE: state_next = RESP;
      WR_ISSUE:   state_next = RESP;
      RESP: begin
        state_next = IDLE;
        err_next   = 1'b0;
      end
      default: begin
        state_next = IDLE;
        err_next   = 1'b0;
      end
    endcase
  end

  // State, request latches and registered outputs (decoded from next state)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      err_q   <= 1'b0;
      word_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready   <= 1'b1;
      ack     <= 1'b0;
      err     <= 1'b0;
      ram_wre <= 1'b0;
    end else begin
      state   <= state_next;
      err_q   <= err_next;
      ready   <= (state_next == IDLE);
      ack     <= (state_next == RESP);
      err     <= (state_next == RESP) && err_next;
      ram_wre <= (state_next == WR_ISSUE);
      if (state == IDLE && req) begin
        word_q  <= addr_in[RAM_AW+1:2];
        wdata_q <= wdata_in;
      end
      if (state == RD_CAPTURE) begin
        rdata_q <= ram_data_out;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural registered-read RAM.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        ready;
  logic        ack;
  logic        err;
  logic [31:0] rdata_out;
  logic        ram_wre;
  logic [15:0] ram_add;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata = 32'd0;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH(64), .RAM_AW(16)) dut (
    .clk(clk), .rst(rst), .req(req), .we_in(we_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .ready(ready), .ack(ack), .err(err),
    .rdata_out(rdata_out), .ram_wre(ram_wre), .ram_add(ram_add),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always @(posedge clk) begin
    if (ram_wre) mem[ram_add[5:0]] <= ram_data_in;
    ram_data_out <= mem[ram_add[5:0]];
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic [15:0] exp_word;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int          lat = 0;
    int          wre_cnt = 0;
    logic [15:0] wre_add = 16'd0;
    logic        got = 1'b0;
    logic        busy_ok = 1'b1;
    logic        got_err = 1'b0;
    logic [31:0] got_rdata = 32'd0;
    @(negedge clk);
    chk("ready_before_req", {31'd0, ready}, 32'd1);
    req = 1'b1; we_in = v.we; addr_in = v.addr; wdata_in = v.wdata;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      req = 1'b0;
      if (ram_wre) begin wre_cnt++; wre_add = ram_add; end
      if (ready) busy_ok = 1'b0;
      if (ack) begin got = 1'b1; lat = k; got_err = err; got_rdata = rdata_out; end
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    chk("ack_latency", lat, v.exp_lat);
    chk("err_flag", {31'd0, got_err}, {31'd0, v.exp_err});
    chk("ready_low_busy", {31'd0, busy_ok}, 32'd1);
    chk("wre_pulses", wre_cnt, (v.we && !v.exp_err) ? 32'd1 : 32'd0);
    if (v.we && !v.exp_err) chk("wre_word", {16'd0, wre_add}, {16'd0, v.exp_word});
    if (!v.we && !v.exp_err) last_rdata = v.exp_rdata;
    chk("rdata_out", got_rdata, last_rdata);
  endtask

  vec_t vecs [11];

  initial begin
    int acks;
    int readies;
    logic overlap;
    logic stray;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 2, 32'd0,          16'd4};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'd0,         1'b0, 3, 32'hDEAD_BEEF, 16'd4};
    vecs[2]  = '{1'b1, 32'h0000_00FC, 32'h1234_5678, 1'b0, 2, 32'd0,          16'd63};
    vecs[3]  = '{1'b0, 32'h0000_00FC, 32'd0,         1'b0, 3, 32'h1234_5678, 16'd63};
    vecs[4]  = '{1'b0, 32'h0000_0100, 32'd0,         1'b1, 1, 32'd0,          16'd0};
    vecs[5]  = '{1'b0, 32'h8000_0000, 32'd0,         1'b1, 1, 32'd0,          16'd0};
    vecs[6]  = '{1'b0, 32'h0000_0012, 32'd0,         1'b1, 1, 32'd0,          16'd0};
    vecs[7]  = '{1'b1, 32'h0000_0104, 32'hFFFF_FFFF, 1'b1, 1, 32'd0,          16'd0};
    vecs[8]  = '{1'b1, 32'h0000_0000, 32'hA5A5_0F0F, 1'b0, 2, 32'd0,          16'd0};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'd0,         1'b0, 3, 32'hA5A5_0F0F, 16'd0};
    vecs[10] = '{1'b0, 32'h0000_0010, 32'd0,         1'b0, 3, 32'hDEAD_BEEF, 16'd4};

    rst = 1'b1; req = 1'b0; we_in = 1'b0; addr_in = 32'd0; wdata_in = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_wre", {31'd0, ram_wre}, 32'd0);
    chk("rst_rdata", rdata_out, 32'd0);
    chk("rst_add", {16'd0, ram_add}, 32'd0);
    chk("rst_wdata", ram_data_in, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_txn(vecs[i]);

    // req held high: one transaction per IDLE visit, period of four cycles
    @(negedge clk);
    req = 1'b1; we_in = 1'b0; addr_in = 32'h0000_0010;
    acks = 0; readies = 0; overlap = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (ack) acks++;
      if (ready) readies++;
      if (ack && ready) overlap = 1'b1;
    end
    req = 1'b0;
    chk("held_req_acks", acks, 32'd4);
    chk("held_req_idle_visits", readies, 32'd4);
    chk("held_req_ack_ready_overlap", {31'd0, overlap}, 32'd0);
    chk("held_req_rdata", rdata_out, 32'hDEAD_BEEF);
    repeat (4) @(negedge clk);

    // asynchronous reset during RD_CAPTURE
    req = 1'b1; we_in = 1'b0; addr_in = 32'h0000_00FC;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_ready", {31'd0, ready}, 32'd1);
    chk("arst_ack", {31'd0, ack}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_wre", {31'd0, ram_wre}, 32'd0);
    chk("arst_rdata", rdata_out, 32'd0);
    chk("arst_add", {16'd0, ram_add}, 32'd0);
    last_rdata = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    stray = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ack) stray = 1'b1;
    end
    chk("arst_no_ack", {31'd0, stray}, 32'd0);
    run_txn(vecs[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
